alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Queues ALU commands in a small FIFO and issues them one at a time to an
//   external combinational ALU. Each result is captured and held until the
//   consumer accepts it. Results leave in command-accept order.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_a/cmd_b/cmd_c/cmd_op  command payload (operands, carry-in, opcode)
//   alu_a/alu_b/alu_c/alu_op  registered drive to the external ALU
//   alu_w/alu_zero/alu_neg    ALU result and flags
//   res_valid/res_ready       result handshake
//   res_w/res_zero/res_neg    captured result and flags
//   res_illegal               high when the issued opcode was 3'd7
//   fifo_count                command FIFO occupancy
//   busy                      high whenever the sequencer is not idle
module alu_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [15:0]            cmd_a,
    input  logic [15:0]            cmd_b,
    input  logic                   cmd_c,
    input  logic [2:0]             cmd_op,
    output logic [15:0]            alu_a,
    output logic [15:0]            alu_b,
    output logic                   alu_c,
    output logic [2:0]             alu_op,
    input  logic [15:0]            alu_w,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            res_w,
    output logic                   res_zero,
    output logic                   res_neg,
    output logic                   res_illegal,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 36;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          push, pop;
    logic          capture, res_clear;

    assign cmd_ready = (fifo_count < FULL_COUNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE);

    // Next-state and control decode
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        res_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                // res_valid is always high here, so res_ready alone completes the handshake
                if (res_ready) begin
                    res_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Storage needs no reset: occupancy is tracked entirely by pointers and count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_c, cmd_op};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_c  <= 1'b0;
            alu_op <= '0;
        end else if (pop) begin
            {alu_a, alu_b, alu_c, alu_op} <= head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_w       <= '0;
            res_zero    <= 1'b0;
            res_neg     <= 1'b0;
            res_illegal <= 1'b0;
        end else if (capture) begin
            res_valid   <= 1'b1;
            res_w       <= alu_w;
            res_zero    <= alu_zero;
            res_neg     <= alu_neg;
            res_illegal <= (alu_op == 3'd7);
        end else if (res_clear) begin
            res_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. Provides a behavioural ALU and a
// queue-based reference model of expected results in accept order.
module tb_alu_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [15:0]   cmd_a, cmd_b;
    logic          cmd_c;
    logic [2:0]    cmd_op;
    logic [15:0]   alu_a, alu_b;
    logic          alu_c;
    logic [2:0]    alu_op;
    logic [15:0]   alu_w;
    logic          alu_zero, alu_neg;
    logic          res_valid, res_ready;
    logic [15:0]   res_w;
    logic          res_zero, res_neg, res_illegal;
    logic [CW-1:0] fifo_count;
    logic          busy;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_c      (cmd_c),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_op     (alu_op),
        .alu_w      (alu_w),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_w      (res_w),
        .res_zero   (res_zero),
        .res_neg    (res_neg),
        .res_illegal(res_illegal),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0 pass A, 1 sub, 2 add, 3 A + (B >>> 1),
    // 4 and, 5 xor, 6 byte concat, 7 illegal -> 0
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic [2:0] op);
        logic signed [15:0] bs;
        bs = $signed(b) >>> 1;
        case (op)
            3'd0:    return a;
            3'd1:    return a - b - {15'd0, c};
            3'd2:    return a + b + {15'd0, c};
            3'd3:    return a + bs;
            3'd4:    return a & b;
            3'd5:    return a ^ b;
            3'd6:    return {a[7:0], b[7:0]};
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        alu_w    = alu_f(alu_a, alu_b, alu_c, alu_op);
        alu_zero = (alu_w == 16'h0000);
        alu_neg  = alu_w[15];
    end

    typedef struct {
        logic [15:0] w;
        logic        z;
        logic        n;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the negedge (they complete at the
    // following posedge), update the model, return 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                acc   = 1'b1;
                e.w   = alu_f(cmd_a, cmd_b, cmd_c, cmd_op);
                e.z   = (e.w == 16'h0000);
                e.n   = e.w[15];
                e.ill = (cmd_op == 3'd7);
                exp_q.push_back(e);
            end
            if (res_valid) begin
                chk("res_pending", 32'(exp_q.size() != 0), 32'd1);
                if (res_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("res_w", 32'(res_w), 32'(e.w));
                    chk("res_zero", 32'(res_zero), 32'(e.z));
                    chk("res_neg", 32'(res_neg), 32'(e.n));
                    chk("res_illegal", 32'(res_illegal), 32'(e.ill));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [2:0] op);
        int n;
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_op = op;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        chk("wait_res", 32'(res_valid), 32'd1);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        res_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_c = 1'b0; cmd_op = '0;
        acc = 1'b0;
        #3;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_w", 32'(res_w), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Add with overflow into sign bit; latency check
        cmd_a = 16'h7FFF; cmd_b = 16'h0001; cmd_c = 1'b0; cmd_op = 3'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("lat_accept", 32'(acc), 32'd1);
        chk("lat_k_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("lat_k1_alu_a", 32'(alu_a), 32'h7FFF);
        chk("lat_k1_alu_op", 32'(alu_op), 32'd2);
        chk("lat_k1_res_valid", 32'(res_valid), 32'd0);
        chk("lat_k1_busy", 32'(busy), 32'd1);
        tick();
        chk("lat_k2_res_valid", 32'(res_valid), 32'd1);
        chk("add_res_w", 32'(res_w), 32'h8000);
        chk("add_neg", 32'(res_neg), 32'd1);
        chk("add_zero", 32'(res_zero), 32'd0);
        release_res();
        chk("add_released", 32'(res_valid), 32'd0);

        // Zero flag and byte concatenation
        send(16'h0000, 16'h5A5A, 1'b0, 3'd0);
        wait_res();
        chk("zero_res_w", 32'(res_w), 32'd0);
        chk("zero_flag", 32'(res_zero), 32'd1);
        release_res();
        send(16'h12AB, 16'h34CD, 1'b0, 3'd6);
        wait_res();
        chk("concat_res_w", 32'(res_w), 32'hABCD);
        release_res();

        // Backpressure until full
        res_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom_range(0, 6)));
        chk("full_count", 32'(fifo_count), 32'(DEPTH));
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_hold_valid", 32'(res_valid), 32'd1);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_no_accept", 32'(acc), 32'd0);
        end
        cmd_valid = 1'b0;
        drain();
        tick();
        chk("drained_count", 32'(fifo_count), 32'd0);
        chk("drained_busy", 32'(busy), 32'd0);

        // Illegal opcode, then arithmetic shift
        res_ready = 1'b0;
        send(16'($urandom), 16'($urandom), 1'b0, 3'd7);
        wait_res();
        chk("illegal_flag", 32'(res_illegal), 32'd1);
        chk("illegal_zero", 32'(res_zero), 32'd1);
        chk("illegal_alu_op", 32'(alu_op), 32'd7);
        release_res();
        send(16'h0010, 16'hFFFE, 1'b0, 3'd3);
        wait_res();
        chk("shift_res_w", 32'(res_w), 32'h000F);
        chk("shift_illegal", 32'(res_illegal), 32'd0);
        release_res();

        // Reset during HOLD with two queued entries
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(16'($urandom), 16'($urandom), 1'b0, 3'd5);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'd0);
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_alu_a", 32'(alu_a), 32'd0);
        chk("async_rst_res_w", 32'(res_w), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_quiet", 32'(res_valid), 32'd0);
        end
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Push in the same cycle IDLE pops the only entry
        res_ready = 1'b0;
        send(16'h1111, 16'h0022, 1'b1, 3'd1);
        chk("cc_count_first", 32'(fifo_count), 32'd1);
        send(16'h0F0F, 16'h00FF, 1'b0, 3'd4);
        chk("cc_count_same", 32'(fifo_count), 32'd1);
        chk("cc_busy", 32'(busy), 32'd1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom);
            cmd_a     = 16'($urandom);
            cmd_b     = 16'($urandom);
            cmd_c     = 1'($urandom);
            cmd_op    = 3'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        drain();
        tick();
        chk("final_count", 32'(fifo_count), 32'd0);
        chk("final_valid", 32'(res_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
